// File: rtl/video_timing_if.sv
// Raster outputs and foreground-prefetch handshake of the video timing generator.
// master: the timing generator; slave: the consumer (prefetch unit / display).
interface video_timing_if;
    logic       prefetch_busy_i;
    logic       hsync_o;
    logic       vsync_o;
    logic       visible_o;
    logic [7:0] display_x_o;
    logic [7:0] display_y_o;
    logic       prefetch_start_o;
    logic [7:0] prefetch_y_o;
    logic       frame_start_o;
    logic       overrun_o;

    modport master (
        input  prefetch_busy_i,
        output hsync_o, vsync_o, visible_o, display_x_o, display_y_o,
        output prefetch_start_o, prefetch_y_o, frame_start_o, overrun_o
    );

    modport slave (
        output prefetch_busy_i,
        input  hsync_o, vsync_o, visible_o, display_x_o, display_y_o,
        input  prefetch_start_o, prefetch_y_o, frame_start_o, overrun_o
    );
endinterface

// File: rtl/video_timing.sv
// 800x525 raster generator with a 512x480 game window (2x scaled to 256x240) and a
// one-deep pending slot for per-line foreground prefetch requests.
module video_timing #(
    parameter int unsigned GAME_X0    = 64,
    parameter int unsigned PREFETCH_H = 576
) (
    input logic            gpu_clk,
    input logic            rst_n,
    video_timing_if.master vt
);
    localparam logic [9:0] GameX0    = 10'(GAME_X0);
    localparam logic [9:0] GameX1    = 10'(GAME_X0 + 512);
    localparam logic [9:0] PrefetchH = 10'(PREFETCH_H);

    logic       run_q;
    logic [9:0] hcount_q, vcount_q, hcount_d, vcount_d;

    logic       hsync_d, vsync_d, visible_d, frame_start_d;
    logic [7:0] display_x_d, display_y_d;

    logic       req_q, req_d;
    logic [7:0] req_y_q, req_y_d;
    logic       pend_q, pend_d;
    logic [7:0] pend_y_q, pend_y_d;
    logic       overrun_q, overrun_d;
    logic       busy, issue, lost;

    // The first edge after reset loads raster (0,0) rather than advancing past it.
    always_comb begin
        hcount_d = '0;
        vcount_d = '0;
        if (run_q) begin
            if (hcount_q == 10'd799) begin
                hcount_d = '0;
                vcount_d = (vcount_q == 10'd524) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 10'd1;
                vcount_d = vcount_q;
            end
        end
    end

    // Outputs are computed from the next raster position so they line up with it.
    always_comb begin
        hsync_d       = !((hcount_d >= 10'd656) && (hcount_d <= 10'd751));
        vsync_d       = !((vcount_d == 10'd490) || (vcount_d == 10'd491));
        visible_d     = (vcount_d < 10'd480) && (hcount_d >= GameX0) && (hcount_d < GameX1);
        display_x_d   = visible_d ? 8'((hcount_d - GameX0) >> 1) : 8'd0;
        display_y_d   = visible_d ? 8'(vcount_d >> 1) : 8'd0;
        frame_start_d = (hcount_d == 10'd0) && (vcount_d == 10'd0);
        req_d         = (hcount_d == PrefetchH) &&
                        ((vcount_d[0] && (vcount_d <= 10'd477)) || (vcount_d == 10'd524));
        req_y_d       = (vcount_d == 10'd524) ? 8'd0 : 8'((vcount_d + 10'd1) >> 1);
    end

    assign busy  = vt.prefetch_busy_i;
    assign issue = !busy && (pend_q || req_q);
    assign lost  = pend_q && busy && req_q;

    // A pending request always wins the issue slot; a fresh one then takes its place.
    always_comb begin
        pend_d    = pend_q;
        pend_y_d  = pend_y_q;
        overrun_d = overrun_q || lost;
        if (req_q && (pend_q || busy)) begin
            pend_d   = 1'b1;
            pend_y_d = req_y_q;
        end else if (pend_q && !busy) begin
            pend_d = 1'b0;
        end
    end

    assign vt.prefetch_start_o = issue;
    assign vt.prefetch_y_o     = issue ? (pend_q ? pend_y_q : req_y_q) : 8'd0;
    assign vt.overrun_o        = overrun_q || lost;

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q            <= 1'b0;
            hcount_q         <= '0;
            vcount_q         <= '0;
            vt.hsync_o       <= 1'b1;
            vt.vsync_o       <= 1'b1;
            vt.visible_o     <= 1'b0;
            vt.display_x_o   <= '0;
            vt.display_y_o   <= '0;
            vt.frame_start_o <= 1'b0;
            req_q            <= 1'b0;
            req_y_q          <= '0;
            pend_q           <= 1'b0;
            pend_y_q         <= '0;
            overrun_q        <= 1'b0;
        end else begin
            run_q            <= 1'b1;
            hcount_q         <= hcount_d;
            vcount_q         <= vcount_d;
            vt.hsync_o       <= hsync_d;
            vt.vsync_o       <= vsync_d;
            vt.visible_o     <= visible_d;
            vt.display_x_o   <= display_x_d;
            vt.display_y_o   <= display_y_d;
            vt.frame_start_o <= frame_start_d;
            req_q            <= req_d;
            req_y_q          <= req_y_d;
            pend_q           <= pend_d;
            pend_y_q         <= pend_y_d;
            overrun_q        <= overrun_d;
        end
    end
endmodule
